// File: rtl/keypad_scan_controller.sv
// 4x4 matrix keypad scan sequencer: walks a one-hot column drive, confirms a single
// pressed key over several settle periods, and hands its code out on a valid/ack port.
module keypad_scan_controller #(
  parameter int SCAN_CYCLES   = 16,
  parameter int CONFIRM_COUNT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_db,
  output logic [3:0] col_drive,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overrun
);

  localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int MW = $clog2(CONFIRM_COUNT + 1);
  localparam logic [CW-1:0] SAMPLE_AT  = CW'(SCAN_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_DONE = MW'(CONFIRM_COUNT);

  typedef enum logic [1:0] {SCAN, CONFIRM, HELD} state_t;

  state_t        state, state_d;
  logic [1:0]    col_idx, col_d;
  logic [1:0]    row_idx, row_d;
  logic [CW-1:0] settle_cnt;
  logic [MW-1:0] match_cnt, match_d;
  logic          sample, single, row_hit, advance, confirm;

  function automatic logic [MW-1:0] sat_inc(input logic [MW-1:0] v);
    return (v == MATCH_DONE) ? v : v + 1'b1;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (v[i]) idx = 2'(i);
    return idx;
  endfunction

  assign sample    = (settle_cnt == SAMPLE_AT);
  // Exactly one row set; two or more is treated as ghosting and ignored.
  assign single    = (rows_db != 4'd0) && ((rows_db & 4'(rows_db - 4'd1)) == 4'd0);
  assign row_hit   = (rows_db == (4'b0001 << row_idx));
  assign col_drive = 4'b0001 << col_idx;
  assign key_down  = (state == HELD);

  always_comb begin
    state_d = state;
    col_d   = col_idx;
    row_d   = row_idx;
    match_d = match_cnt;
    advance = 1'b0;
    confirm = 1'b0;
    if (sample) begin
      case (state)
        SCAN: begin
          if (single) begin
            row_d   = onehot_idx(rows_db);
            match_d = '0;
            state_d = CONFIRM;
          end else begin
            advance = 1'b1;
          end
        end
        CONFIRM: begin
          if (row_hit) begin
            match_d = sat_inc(match_cnt);
            if (match_d == MATCH_DONE) begin
              state_d = HELD;
              match_d = '0;
              confirm = 1'b1;
            end
          end else begin
            state_d = SCAN;
            advance = 1'b1;
          end
        end
        HELD: begin
          match_d = rows_db[row_idx] ? '0 : sat_inc(match_cnt);
          if (match_d == MATCH_DONE) begin
            state_d = SCAN;
            match_d = '0;
            advance = 1'b1;
          end
        end
        default: state_d = SCAN;
      endcase
    end
    if (advance) col_d = col_idx + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= SCAN;
      col_idx    <= 2'd0;
      row_idx    <= 2'd0;
      settle_cnt <= '0;
      match_cnt  <= '0;
    end else begin
      state     <= state_d;
      col_idx   <= col_d;
      row_idx   <= row_d;
      match_cnt <= match_d;
      settle_cnt <= (sample || advance) ? '0 : settle_cnt + 1'b1;
    end
  end

  // Output handshake: a confirm loads the key unless an unaccepted one is still pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (confirm) begin
        if (key_valid && !key_ack) begin
          overrun <= 1'b1;
        end else begin
          key_code  <= {row_idx, col_idx};
          key_valid <= 1'b1;
        end
      end else if (key_valid && key_ack) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Bench for keypad_scan_controller with SCAN_CYCLES=4, CONFIRM_COUNT=2: per-cycle vector
// table for idle scanning and ghosting, then hand-timed press/release/handshake sequences.
module tb_keypad_scan_controller;

  logic       clk;
  logic       reset;
  logic [3:0] rows_db;
  logic [3:0] col_drive;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_down;
  logic       overrun;

  keypad_scan_controller #(.SCAN_CYCLES(4), .CONFIRM_COUNT(2)) dut (
    .clk(clk), .reset(reset), .rows_db(rows_db), .col_drive(col_drive),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .key_down(key_down), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rows;
    logic [3:0] exp_col;
    logic       exp_valid;
    logic       exp_down;
    logic       exp_ovr;
  } vec_t;

  vec_t       vecs[32];
  logic [3:0] sb[$];
  int         checks = 0;
  int         failures = 0;
  int         rel = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    rel = rel + 1;
  endtask

  task automatic run_to(input int n);
    while (rel < n) step();
  endtask

  task automatic wait_col_start(input logic [3:0] target, input string name);
    logic [3:0] prev;
    int n;
    bit found;
    n = 0;
    found = 0;
    while (n < 40 && !found) begin
      prev = col_drive;
      step();
      n++;
      if (col_drive == target && prev != target) found = 1;
    end
    check(name, 32'(found), 32'd1);
    rel = 0;
  endtask

  // Pops the scoreboard at a transfer and checks the presented code against it.
  task automatic ack_transfer(input string name);
    logic [3:0] exp;
    check({name, "_valid"}, 32'(key_valid), 32'd1);
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
      exp = 4'hx;
    end else begin
      exp = sb.pop_front();
    end
    check({name, "_code"}, 32'(key_code), 32'(exp));
    key_ack = 1'b1;
    step();
    key_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      vecs[i].rows      = (i >= 20 && i < 24) ? 4'b0011 : 4'b0000;
      vecs[i].exp_col   = 4'(1 << ((i / 4) % 4));
      vecs[i].exp_valid = 1'b0;
      vecs[i].exp_down  = 1'b0;
      vecs[i].exp_ovr   = 1'b0;
    end

    reset   = 1'b0;
    rows_db = 4'd0;
    key_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("reset_code", 32'(key_code), 32'd0);

    // Idle scanning, then a ghost pattern held over the whole of column 1.
    for (int i = 0; i < 32; i++) begin
      rows_db = vecs[i].rows;
      check($sformatf("vec%0d", i),
            32'({col_drive, key_valid, key_down, overrun}),
            32'({vecs[i].exp_col, vecs[i].exp_valid, vecs[i].exp_down, vecs[i].exp_ovr}));
      step();
    end
    rows_db = 4'd0;

    // Press row 2 on column 1 -> code 9.
    wait_col_start(4'b0010, "t2_sync");
    rows_db = 4'b0100;
    sb.push_back(4'h9);
    run_to(11);
    check("t2_valid_early", 32'(key_valid), 32'd0);
    check("t2_down_early", 32'(key_down), 32'd0);
    run_to(12);
    check("t2_valid", 32'(key_valid), 32'd1);
    check("t2_code_peek", 32'(key_code), 32'h9);
    check("t2_down", 32'(key_down), 32'd1);
    check("t2_col_held", 32'(col_drive), 32'b0010);

    ack_transfer("t3_ack");
    check("t3_valid_cleared", 32'(key_valid), 32'd0);
    run_to(16);
    rows_db = 4'd0;
    run_to(23);
    check("t3_down_before", 32'(key_down), 32'd1);
    run_to(24);
    check("t3_down_after", 32'(key_down), 32'd0);
    check("t3_col_resume", 32'(col_drive), 32'b0100);
    check("t3_no_second", 32'(key_valid), 32'd0);

    // Bounce during CONFIRM.
    wait_col_start(4'b0001, "t4_sync");
    rows_db = 4'b0001;
    run_to(4);
    rows_db = 4'd0;
    check("t4_col_held", 32'(col_drive), 32'b0001);
    run_to(8);
    check("t4_col_adv", 32'(col_drive), 32'b0010);
    check("t4_no_valid", 32'(key_valid), 32'd0);
    check("t4_no_down", 32'(key_down), 32'd0);

    // First key (row1,col0 -> 4) left unacknowledged; second key overruns.
    wait_col_start(4'b0001, "t5_sync");
    rows_db = 4'b0010;
    sb.push_back(4'h4);
    run_to(12);
    check("t5_valid1", 32'(key_valid), 32'd1);
    check("t5_code1", 32'(key_code), 32'h4);
    rows_db = 4'd0;
    run_to(20);
    check("t5_col1", 32'(col_drive), 32'b0010);
    check("t5_down_released", 32'(key_down), 32'd0);
    rows_db = 4'b1000;
    run_to(31);
    check("t5_ovr_before", 32'(overrun), 32'd0);
    run_to(32);
    check("t5_overrun", 32'(overrun), 32'd1);
    check("t5_code_kept", 32'(key_code), 32'h4);
    check("t5_valid_kept", 32'(key_valid), 32'd1);
    check("t5_down2", 32'(key_down), 32'd1);
    rows_db = 4'd0;
    run_to(33);
    check("t5_ovr_pulse", 32'(overrun), 32'd0);
    run_to(40);
    check("t5_col2", 32'(col_drive), 32'b0100);
    rows_db = 4'b0001;
    sb.push_back(4'h2);
    run_to(51);
    ack_transfer("t5_coincide");
    check("t5_valid_stays", 32'(key_valid), 32'd1);
    check("t5_new_code", 32'(key_code), 32'(sb[0]));
    check("t5_no_ovr", 32'(overrun), 32'd0);
    check("t5_held", 32'(key_down), 32'd1);

    // Reset while HELD with a pending key.
    reset = 1'b0;
    step();
    reset   = 1'b1;
    rows_db = 4'd0;
    sb.delete();
    check("t6_valid", 32'(key_valid), 32'd0);
    check("t6_code", 32'(key_code), 32'd0);
    check("t6_down", 32'(key_down), 32'd0);
    check("t6_ovr", 32'(overrun), 32'd0);
    check("t6_col", 32'(col_drive), 32'b0001);
    run_to(56);
    check("t6_col_hold", 32'(col_drive), 32'b0001);
    run_to(57);
    check("t6_col_step", 32'(col_drive), 32'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
